// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the IF/LSU memory port arbiter: FSM states and owner encoding.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_e;

    localparam logic OWNER_IF  = 1'b0;
    localparam logic OWNER_LSU = 1'b1;

endpackage

// File: rtl/wait_timer.sv
// Watchdog for an outstanding memory transaction; expired is combinational in the
// TIMEOUT-th enabled cycle after clr. TIMEOUT = 0 never expires.
module wait_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT);

    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;

    always_comb begin
        cnt_inc = cnt_q + 1'b1;
        cnt_d   = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_inc;
        end
        // The current busy cycle counts towards the limit.
        expired = en && (TIMEOUT != 0) && (cnt_inc == LIMIT);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and LSU, one transaction at a time, LSU first.
// Grant and response are combinational pass-throughs; requesters hold req until gnt.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    if_req_i,
    input  logic [ADDR_WIDTH-1:0]   if_addr_i,
    input  logic                    if_flush_i,
    output logic                    if_gnt_o,
    output logic                    if_rvalid_o,
    output logic [DATA_WIDTH-1:0]   if_rdata_o,
    input  logic                    lsu_req_i,
    input  logic                    lsu_we_i,
    input  logic [DATA_WIDTH/8-1:0] lsu_be_i,
    input  logic [ADDR_WIDTH-1:0]   lsu_addr_i,
    input  logic [DATA_WIDTH-1:0]   lsu_wdata_i,
    output logic                    lsu_gnt_o,
    output logic                    lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0]   lsu_rdata_o,
    output logic                    mem_req_o,
    output logic                    mem_we_o,
    output logic [DATA_WIDTH/8-1:0] mem_be_o,
    output logic [ADDR_WIDTH-1:0]   mem_addr_o,
    output logic [DATA_WIDTH-1:0]   mem_wdata_o,
    input  logic                    mem_gnt_i,
    input  logic                    mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
    output logic                    stall_o,
    output logic                    err_o
);

    arb_state_e            state_q, state_d;
    logic                  drop_q, drop_d;
    logic                  timer_clr, timer_en, expired;
    logic                  sel_lsu, sel_if, owner, drop_now;
    logic                  rsp_vld, if_vld, lsu_vld;
    logic [DATA_WIDTH-1:0] rsp_dat;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        mem_be_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if_gnt_o    = 1'b0;
        lsu_gnt_o   = 1'b0;
        rsp_vld     = 1'b0;
        rsp_dat     = '0;
        err_o       = 1'b0;
        timer_clr   = (state_q == IDLE);
        timer_en    = 1'b0;
        sel_lsu     = lsu_req_i;
        // A fetch on a flushed path is never started.
        sel_if      = !lsu_req_i && if_req_i && !if_flush_i;
        owner       = (state_q == BUSY_D) ? OWNER_LSU : OWNER_IF;
        drop_now    = drop_q || if_flush_i;

        case (state_q)
            IDLE: begin
                if (sel_lsu) begin
                    mem_req_o   = 1'b1;
                    mem_we_o    = lsu_we_i;
                    mem_be_o    = lsu_be_i;
                    mem_addr_o  = lsu_addr_i;
                    mem_wdata_o = lsu_wdata_i;
                    lsu_gnt_o   = mem_gnt_i;
                    if (mem_gnt_i) state_d = BUSY_D;
                end else if (sel_if) begin
                    mem_req_o  = 1'b1;
                    mem_be_o   = '1;
                    mem_addr_o = if_addr_i;
                    if_gnt_o   = mem_gnt_i;
                    if (mem_gnt_i) state_d = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                timer_en = 1'b1;
                if (mem_rvalid_i) begin
                    rsp_vld = 1'b1;
                    rsp_dat = mem_rdata_i;
                    state_d = IDLE;
                end else if (expired) begin
                    rsp_vld = 1'b1;
                    err_o   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        drop_d       = (state_q == BUSY_I) && !rsp_vld && drop_now;
        if_vld       = rsp_vld && (owner == OWNER_IF) && !drop_now;
        lsu_vld      = rsp_vld && (owner == OWNER_LSU);
        if_rvalid_o  = if_vld;
        if_rdata_o   = if_vld ? rsp_dat : '0;
        lsu_rvalid_o = lsu_vld;
        lsu_rdata_o  = lsu_vld ? rsp_dat : '0;
        stall_o      = lsu_req_i && !lsu_rvalid_o;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: stimulus pushes expected responses, a monitor checks them.
module tb_mem_port_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        if_req_i, if_flush_i, if_gnt_o, if_rvalid_o;
    logic [31:0] if_addr_i, if_rdata_o;
    logic        lsu_req_i, lsu_we_i, lsu_gnt_o, lsu_rvalid_o;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i, lsu_rdata_o;
    logic        mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic        stall_o, err_o;

    typedef struct {
        bit          is_lsu;
        logic [31:0] data;
        bit          err;
    } rsp_t;

    rsp_t exp_q[$];
    rsp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clk_i = ~clk_i;

    mem_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
        .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic nxt();
        @(posedge clk_i);
        #1;
    endtask

    task automatic quiet();
        if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
        lsu_req_i = 0; lsu_we_i = 0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    endtask

    task automatic push(input bit is_lsu, input logic [31:0] data, input bit err);
        rsp_t e;
        e.is_lsu = is_lsu;
        e.data   = data;
        e.err    = err;
        exp_q.push_back(e);
    endtask

    // Response monitor: every rvalid/err pulse must match the oldest expected entry.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            if (if_rvalid_o || lsu_rvalid_o || err_o) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_rsp: if_rvalid=%0b lsu_rvalid=%0b err=%0b, expected none at %0t",
                             if_rvalid_o, lsu_rvalid_o, err_o, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("rsp_owner", {30'd0, if_rvalid_o, lsu_rvalid_o}, mon_e.is_lsu ? 32'd1 : 32'd2);
                    chk("rsp_data", mon_e.is_lsu ? lsu_rdata_o : if_rdata_o, mon_e.data);
                    chk("rsp_err", {31'd0, err_o}, {31'd0, mon_e.err});
                end
            end
            if (!if_rvalid_o)  chk("if_rdata_zero", if_rdata_o, 32'h0);
            if (!lsu_rvalid_o) chk("lsu_rdata_zero", lsu_rdata_o, 32'h0);
        end
    end

    initial begin
        rst_i = 1;
        quiet();
        @(negedge clk_i);
        chk("rst_ctl", {19'd0, mem_req_o, mem_we_o, mem_be_o, if_gnt_o, lsu_gnt_o,
                        if_rvalid_o, lsu_rvalid_o, stall_o, err_o, 2'b00}, 32'h0);
        chk("rst_bus", mem_addr_o | mem_wdata_o | if_rdata_o | lsu_rdata_o, 32'h0);
        nxt(); nxt();
        rst_i = 0;

        // Single fetch: grant in cycle 0, response in cycle 2.
        if_req_i = 1; if_addr_i = 32'h100; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("f_gnt", {31'd0, if_gnt_o}, 32'd1);
        chk("f_addr", mem_addr_o, 32'h100);
        chk("f_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h0F);
        chk("f_stall0", {31'd0, stall_o}, 32'd0);
        nxt();
        if_req_i = 0; mem_gnt_i = 0;
        @(negedge clk_i);
        chk("f_busy_req", {31'd0, mem_req_o}, 32'd0);
        chk("f_stall1", {31'd0, stall_o}, 32'd0);
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0013; push(0, 32'h0000_0013, 0);
        @(negedge clk_i);
        chk("f_stall2", {31'd0, stall_o}, 32'd0);
        nxt();
        quiet();

        // Simultaneous requests: LSU first, IF granted right after lsu_rvalid.
        if_req_i = 1; if_addr_i = 32'h104;
        lsu_req_i = 1; lsu_addr_i = 32'h3000; lsu_be_i = 4'hF; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("s_lsu_gnt", {30'd0, lsu_gnt_o, if_gnt_o}, 32'd2);
        chk("s_addr", mem_addr_o, 32'h3000);
        chk("s_stall0", {31'd0, stall_o}, 32'd1);
        nxt();
        mem_gnt_i = 0;
        @(negedge clk_i);
        chk("s_stall1", {31'd0, stall_o}, 32'd1);
        chk("s_if_wait", {31'd0, if_gnt_o}, 32'd0);
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'hCAFE_0001; push(1, 32'hCAFE_0001, 0);
        @(negedge clk_i);
        chk("s_stall_rsp", {31'd0, stall_o}, 32'd0);
        nxt();
        lsu_req_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("s_if_gnt", {31'd0, if_gnt_o}, 32'd1);
        chk("s_if_addr", mem_addr_o, 32'h104);
        nxt();
        if_req_i = 0; mem_gnt_i = 0;
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h00A0_0093; push(0, 32'h00A0_0093, 0);
        nxt();
        quiet();

        // Partial store.
        lsu_req_i = 1; lsu_we_i = 1; lsu_be_i = 4'b0011;
        lsu_wdata_i = 32'hDEAD_BEEF; lsu_addr_i = 32'h2000; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("st_gnt", {31'd0, lsu_gnt_o}, 32'd1);
        chk("st_we_be", {27'd0, mem_we_o, mem_be_o}, 32'h13);
        chk("st_wdata", mem_wdata_o, 32'hDEAD_BEEF);
        chk("st_addr", mem_addr_o, 32'h2000);
        nxt();
        mem_gnt_i = 0;
        nxt();
        mem_rvalid_i = 1; push(1, 32'h0, 0);
        nxt();
        quiet();

        // Flush one cycle after fetch grant; response must vanish, next fetch is normal.
        if_req_i = 1; if_addr_i = 32'h200; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("fl_gnt", {31'd0, if_gnt_o}, 32'd1);
        nxt();
        if_req_i = 0; mem_gnt_i = 0; if_flush_i = 1;
        nxt();
        if_flush_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h1111_1111;
        @(negedge clk_i);
        chk("fl_dropped", {31'd0, if_rvalid_o}, 32'd0);
        nxt();
        quiet();
        if_req_i = 1; if_addr_i = 32'h204; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("fl_next_gnt", {31'd0, if_gnt_o}, 32'd1);
        nxt();
        if_req_i = 0; mem_gnt_i = 0;
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h2222_2222; push(0, 32'h2222_2222, 0);
        nxt();
        quiet();

        // Timeout: LSU granted, memory silent; abort in 4th busy cycle.
        lsu_req_i = 1; lsu_addr_i = 32'h3004; lsu_be_i = 4'hF; mem_gnt_i = 1;
        nxt();
        mem_gnt_i = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk_i);
            chk("to_no_err", {31'd0, err_o}, 32'd0);
            nxt();
        end
        push(1, 32'h0, 1);
        @(negedge clk_i);
        chk("to_err", {31'd0, err_o}, 32'd1);
        nxt();
        mem_gnt_i = 1;
        @(negedge clk_i);
        chk("to_regrant", {31'd0, lsu_gnt_o}, 32'd1);
        nxt();
        mem_gnt_i = 0;
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0005; push(1, 32'h5, 0);
        nxt();
        quiet();

        // Reset while BUSY_D, then a late response that must be ignored.
        lsu_req_i = 1; lsu_addr_i = 32'h3008; lsu_be_i = 4'hF; mem_gnt_i = 1;
        nxt();
        quiet();
        rst_i = 1;
        nxt();
        rst_i = 0; mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0077;
        @(negedge clk_i);
        chk("rm_ctl", {19'd0, mem_req_o, mem_we_o, mem_be_o, if_gnt_o, lsu_gnt_o,
                       if_rvalid_o, lsu_rvalid_o, stall_o, err_o, 2'b00}, 32'h0);
        chk("rm_bus", mem_addr_o | mem_wdata_o | if_rdata_o | lsu_rdata_o, 32'h0);
        nxt();
        quiet();
        if_req_i = 1; if_addr_i = 32'h300; mem_gnt_i = 1;
        @(negedge clk_i);
        chk("rm_idle_gnt", {31'd0, if_gnt_o}, 32'd1);
        nxt();
        quiet();
        nxt();
        mem_rvalid_i = 1; mem_rdata_i = 32'h0000_0033; push(0, 32'h33, 0);
        nxt();
        quiet();
        nxt(); nxt();

        chk("sb_drain", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port instruction/data memory between the fetch stage (IF) and the load/store path in MEM of the 5-stage pipeline. Grants one transaction at a time, routes the response back to its owner and drops fetch responses cancelled by a taken branch. Raises a stall while the data side is blocked and a timeout error if memory never answers.

## Interface
- DATA_WIDTH, 32, data bus width
- ADDR_WIDTH, 32, byte address width
- TIMEOUT, 255, cycles in a BUSY state without `mem_rvalid_i` before abort; 0 disables
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous, active-high reset
- if_req_i / if_addr_i  in  1 / ADDR_WIDTH  fetch read request
- if_flush_i  in  1  branch taken; cancel the current fetch
- if_gnt_o / if_rvalid_o / if_rdata_o  out  1 / 1 / DATA_WIDTH  fetch grant and response
- lsu_req_i / lsu_we_i / lsu_be_i  in  1 / 1 / DATA_WIDTH/8  data request, write enable, byte enables
- lsu_addr_i / lsu_wdata_i  in  ADDR_WIDTH / DATA_WIDTH  data address and write data
- lsu_gnt_o / lsu_rvalid_o / lsu_rdata_o  out  1 / 1 / DATA_WIDTH  data grant and response (rvalid also for writes)
- mem_req_o / mem_we_o / mem_be_o / mem_addr_o / mem_wdata_o  out  memory request channel
- mem_gnt_i / mem_rvalid_i / mem_rdata_i  in  1 / 1 / DATA_WIDTH  memory grant and response
- stall_o  out  1  pipeline freeze: LSU is requesting and waiting
- err_o  out  1  one-cycle pulse on timeout abort

## Operation
- The FSM has three states: IDLE, BUSY_I and BUSY_D. Reset value is IDLE.
- IDLE:
  - The arbiter drives `mem_*` combinationally from the selected requester.
  - LSU has fixed priority over IF, because it serves the older instruction.
  - IF is not selected in any cycle where `if_flush_i` is high.
  - When `mem_gnt_i` is high, the owner's `*_gnt_o` is driven high and the FSM moves to BUSY_I or BUSY_D.
  - `mem_we_o` is forced to 0 for IF. `mem_be_o` is all ones for IF.
- BUSY_x:
  - `mem_req_o` is 0. Requests are not granted.
  - When `mem_rvalid_i` is high, `mem_rdata_i` passes to the owner's `*_rdata_o` and the owner's `*_rvalid_o` is driven high in the same cycle. The FSM then returns to IDLE.
- Drop flag:
  - `if_flush_i` in BUSY_I, or in the cycle IF is granted, sets the drop flag.
  - When the drop flag is set, the IF response completes the transaction but `if_rvalid_o` stays 0.
  - The drop flag clears on return to IDLE.
- Timeout:
  - A wait counter (width clog2(TIMEOUT+1)) clears on entry to BUSY and increments each BUSY cycle.
  - When the counter reaches TIMEOUT:
    - `err_o` is driven high for one cycle.
    - The owner's `*_rvalid_o` is driven high with rdata = 0. For IF this is suppressed if the drop flag is set.
    - The FSM returns to IDLE.
- `stall_o` = lsu_req_i && !(lsu_rvalid_o). It is combinational. It is high in IDLE while IF holds the memory or while waiting for grant.
- Stray `mem_rvalid_i` in IDLE (for example after reset mid-transaction) is ignored.
- `if_rdata_o` and `lsu_rdata_o` are 0 whenever the matching rvalid is 0.

## Timing
- After reset, every output is 0, the FSM is in IDLE, the drop flag is clear and the counter is 0.
- Grant has zero added latency: it follows `mem_gnt_i` in IDLE in the same cycle.
- Response has zero added latency: it follows `mem_rvalid_i` in the same cycle.
- Minimum spacing is one transaction per 2 cycles: request/grant in cycle N, rvalid in cycle N+1, next grant in cycle N+2.
- Requesters must hold req and its payload stable until `*_gnt_o`.
- Reset mid-transaction:
  - The FSM goes to IDLE and the drop flag and counter clear on the next edge.
  - No rvalid is emitted for the aborted transaction.
- If flush and rvalid arrive in the same BUSY_I cycle, the response is dropped.

## Structure
- A shared package holds:
  - the state enum `arb_state_e` (IDLE, BUSY_I, BUSY_D);
  - the owner encoding `OWNER_IF` / `OWNER_LSU`.
- The timeout watchdog is a sub-module `wait_timer` with ports clr, en, expired and parameter TIMEOUT (0 means never expires).
- Everything else lives in one module.

## Test plan
- Single fetch:
  - Stimulus: `if_req_i`=1, addr 0x100, `mem_gnt_i` in cycle 0, rvalid with 0x00000013 in cycle 2.
  - Required: `if_gnt_o` high in cycle 0, `if_rvalid_o` and `if_rdata_o`=0x00000013 in cycle 2, `stall_o` never high.
- Simultaneous requests:
  - Stimulus: `if_req_i` and `lsu_req_i` both raised in cycle 0.
  - Required: LSU is granted first and IF is granted in the cycle after `lsu_rvalid_o`. `stall_o` is high from cycle 0 until `lsu_rvalid_o`.
- Store:
  - Stimulus: `lsu_we_i`=1, be 0b0011, wdata 0xDEADBEEF, addr 0x2000.
  - Required: `mem_we_o`=1, `mem_be_o`=0b0011 and `mem_wdata_o`=0xDEADBEEF on the grant cycle; `lsu_rvalid_o` pulses on response.
- Flush:
  - Stimulus: `if_flush_i` one cycle after IF is granted.
  - Required: `if_rvalid_o` stays 0 when the response arrives; the next fetch responds normally.
- Timeout:
  - Stimulus: TIMEOUT=4, LSU granted, no rvalid.
  - Required: `err_o` and `lsu_rvalid_o` (rdata 0) pulse in the 4th BUSY cycle; the next request is granted.
- Reset mid-transaction:
  - Stimulus: `rst_i` asserted in BUSY_D, then a late `mem_rvalid_i`.
  - Required: no `lsu_rvalid_o`, all outputs 0, the FSM is in IDLE.
